// File: rtl/dmem_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
// A request transfers on a rising edge where req_valid && req_ready; a response transfers on a rising edge where rsp_valid && rsp_ready; a presenter holds its payload stable until that edge.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed response latency and RISC-V B/H/W load extension.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned H/W accesses return rsp_err instead of being force-aligned.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned LATENCY    = 2
) (
    input  logic       clk,
    input  logic       rst,
    dmem_if.slave      bus,
    output logic [1:0] dbg_state_o
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_e;

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       we_q, err_q;
    logic [2:0] f3_q;
    logic [1:0] lane_q;
    logic [31:0] rword_q;

    logic [31:0] mem [2**(ADDR_WIDTH-2)];

    logic [ADDR_WIDTH-1:0] eff_addr;
    logic [ADDR_WIDTH-3:0] idx;
    logic        misalign, illegal, err_d, accept, wr_en;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^bus.req_addr[31:ADDR_WIDTH];
    assign idx    = eff_addr[ADDR_WIDTH-1:2];
    assign accept = bus.req_valid & bus.req_ready;
    assign wr_en  = accept & bus.req_we & ~err_d;

    // Request decode: alignment handling, legality and store byte lanes.
    always_comb begin
        eff_addr = bus.req_addr[ADDR_WIDTH-1:0];
        misalign = 1'b0;
        case (bus.req_funct3[1:0])
`ifdef DMEM_MISALIGN_TRAP_EN
            2'b01:   misalign = eff_addr[0];
            2'b10:   misalign = |eff_addr[1:0];
`else
            2'b01:   eff_addr[0] = 1'b0;
            2'b10:   eff_addr[1:0] = 2'b00;
`endif
            default: ;
        endcase
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = bus.req_we;
            default:                illegal = 1'b1;
        endcase
        err_d = illegal | misalign;
        case (bus.req_funct3[1:0])
            2'b00: begin
                be = 4'b0001 << eff_addr[1:0];
                wd = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be = eff_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = bus.req_wdata;
            end
        endcase
    end

    // Memory is never reset; a store commits and a load samples at the accept edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && be[i]) mem[idx][i*8 +: 8] <= wd[i*8 +: 8];
        end
        if (accept) rword_q <= mem[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'b000;
            lane_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q   <= bus.req_we;
                err_q  <= err_d;
                f3_q   <= bus.req_funct3;
                lane_q <= eff_addr[1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ld_byte = rword_q[lane_q*8 +: 8];
        ld_half = lane_q[1] ? rword_q[31:16] : rword_q[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            3'b010:  ld_data = rword_q;
            default: ld_data = 32'd0;
        endcase
        bus.req_ready = (state_q == S_IDLE) & ~rst;
        bus.rsp_valid = (state_q == S_RESP);
        bus.rsp_err   = (state_q == S_RESP) & err_q;
        bus.rsp_rdata = ((state_q == S_RESP) && !we_q && !err_q) ? ld_data : 32'd0;
        dbg_state_o   = state_q;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: expected responses are queued at accept and checked by a separate monitor.
module tb_dmem_responder;
    localparam int LAT = 2;
    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    dmem_if     bus ();

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(17), .LATENCY(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit pending = 1'b0;
    logic [32:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: latency on the first valid cycle, payload on the handshake cycle.
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst && bus.rsp_valid) begin
            if (pending) begin
                pending = 1'b0;
                check("latency", 32'(cyc + 1 - acc_cyc), LAT);
            end
            if (bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rdata 0x%08h with empty queue", bus.rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", bus.rsp_rdata, e[31:0]);
                    check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e[32]});
                end
            end
        end
    end

    // Called at posedge+#1; returns at accept edge+#1 with req_valid dropped.
    task automatic send(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wdata, input bit expect_rsp, input logic [32:0] exp);
        bit done = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_funct3 = f3;
        bus.req_wdata  = wdata;
        for (int i = 0; i < 50 && !done; i++) begin
            done = bus.req_ready;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_fail++;
            $display("FAIL accept_timeout: got no req_ready for addr 0x%08h required accept", addr);
        end else if (expect_rsp) begin
            exp_q.push_back(exp);
            pending = 1'b1;
            acc_cyc = cyc;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL rsp_timeout: got %0d outstanding responses required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic txn(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wdata, input logic [32:0] exp);
        send(we, addr, f3, wdata, 1'b1, exp);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1);
    end

    initial begin
        logic [32:0] mis_w, mis_h;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis_w = {1'b1, 32'h0000_0000};
        mis_h = {1'b1, 32'h0000_0000};
`else
        mis_w = {1'b0, 32'h8000_ABF1};
        mis_h = {1'b0, 32'hFFFF_8000};
`endif
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_funct3 = 3'd0;
        bus.req_wdata  = 32'd0;
        bus.rsp_ready  = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("post_rst_state", {30'd0, dbg_state}, 32'd0);
        @(posedge clk);
        #1;

        // Basic word round trip and load extensions.
        txn(1'b1, 32'h100, F_W,  32'h8000_00F1, {1'b0, 32'h0});
        txn(1'b0, 32'h100, F_W,  32'h0,         {1'b0, 32'h8000_00F1});
        txn(1'b0, 32'h100, F_B,  32'h0,         {1'b0, 32'hFFFF_FFF1});
        txn(1'b0, 32'h100, F_BU, 32'h0,         {1'b0, 32'h0000_00F1});
        txn(1'b0, 32'h102, F_H,  32'h0,         {1'b0, 32'hFFFF_8000});
        txn(1'b0, 32'h102, F_HU, 32'h0,         {1'b0, 32'h0000_8000});
        txn(1'b1, 32'h101, F_B,  32'h0000_00AB, {1'b0, 32'h0});
        txn(1'b0, 32'h100, F_W,  32'h0,         {1'b0, 32'h8000_ABF1});

        // Half and byte stores into a fresh word.
        txn(1'b1, 32'h104, F_W,  32'h1122_3344, {1'b0, 32'h0});
        txn(1'b1, 32'h106, F_H,  32'hFFFF_BEEF, {1'b0, 32'h0});
        txn(1'b0, 32'h104, F_W,  32'h0,         {1'b0, 32'hBEEF_3344});
        txn(1'b0, 32'h106, F_H,  32'h0,         {1'b0, 32'hFFFF_BEEF});
        txn(1'b0, 32'h107, F_B,  32'h0,         {1'b0, 32'hFFFF_FFBE});
        txn(1'b0, 32'h105, F_BU, 32'h0,         {1'b0, 32'h0000_0033});

        // Back-pressure: response held, new requests ignored.
        bus.rsp_ready = 1'b0;
        send(1'b0, 32'h100, F_W, 32'h0, 1'b1, {1'b0, 32'h8000_ABF1});
        repeat (LAT - 1) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            check("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("hold_rsp_rdata", bus.rsp_rdata, 32'h8000_ABF1);
            check("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
            bus.req_valid  = 1'b1;
            bus.req_we     = 1'b1;
            bus.req_addr   = 32'h100;
            bus.req_funct3 = F_W;
            bus.req_wdata  = 32'hDEAD_BEEF;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_req_ready", {31'd0, bus.req_ready}, 32'd1);
        drain();
        txn(1'b0, 32'h100, F_W, 32'h0, {1'b0, 32'h8000_ABF1});

        // Illegal encodings.
        txn(1'b0, 32'h100, 3'b011, 32'h0,         {1'b1, 32'h0});
        txn(1'b1, 32'h100, F_BU,   32'h1234_5678, {1'b1, 32'h0});
        txn(1'b1, 32'h100, 3'b111, 32'h1234_5678, {1'b1, 32'h0});
        txn(1'b0, 32'h100, F_W,    32'h0,         {1'b0, 32'h8000_ABF1});

        // Misalignment and address aliasing.
        txn(1'b0, 32'h102,   F_W, 32'h0, mis_w);
        txn(1'b0, 32'h103,   F_H, 32'h0, mis_h);
        txn(1'b0, 32'h2_0100, F_W, 32'h0, {1'b0, 32'h8000_ABF1});

        // Reset while waiting: response dropped, committed store kept.
        send(1'b0, 32'h100, F_W, 32'h0, 1'b0, 33'd0);
        check("wait_state", {30'd0, dbg_state}, 32'd1);
        rst = 1'b1;
        pending = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("midrst_state", {30'd0, dbg_state}, 32'd0);
        check("midrst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("after_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("after_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        send(1'b1, 32'h108, F_W, 32'h55AA_55AA, 1'b0, 33'd0);
        rst = 1'b1;
        pending = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        txn(1'b0, 32'h108, F_W, 32'h0, {1'b0, 32'h55AA_55AA});
        txn(1'b0, 32'h100, F_W, 32'h0, {1'b0, 32'h8000_ABF1});
        txn(1'b0, 32'h104, F_W, 32'h0, {1'b0, 32'hBEEF_3344});

        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
